uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/cfm_uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfm_uart_pkg.sv
// Shared types and frame constants for the UART receive path.
package cfm_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 8;
    localparam int DATA_BITS    = 8;

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; a push into a full FIFO
// without a same-cycle pop is dropped and reported on drop_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_core,
    input  logic             core_reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot the same cycle, so a full FIFO can accept a push alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & full_o & ~do_pop;

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_core) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small FWFT receive FIFO,
// plus sticky frame-error and overrun flags.
module uart_rx_fifo
    import cfm_uart_pkg::*;
#(
    parameter int TICK_DIV   = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_core,
    input  logic       core_reset_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push, frame_set;
    logic                 ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 fifo_empty, fifo_full, fifo_drop;

    // Reset to the idle level so releasing reset with rx low is not seen as a start edge.
    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                // Edge rather than level: a held break cannot retrigger until rx goes high.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TCNT_W'(START_SAMPLE - 1)) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rx_sync_q ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
                        shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_W'(DATA_BITS - 1)) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
                        state_d   = IDLE;
                        push      = rx_sync_q;
                        frame_set = ~rx_sync_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            div_q   <= '0;
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Set events take priority over a same-cycle clear.
    assign ferr_d = frame_set | (ferr_q & ~clr_err);
    assign ovr_d  = fifo_drop | (ovr_q & ~clr_err);

    always_ff @(posedge clk_core or negedge core_reset_n) begin
        if (!core_reset_n) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_core     (clk_core),
        .core_reset_n (core_reset_n),
        .push_i       (push),
        .data_i       (shreg_q),
        .pop_i        (rd),
        .data_o       (rdata),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .drop_o       (fifo_drop)
    );

    assign rvalid    = ~fifo_empty;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo at TICK_DIV=1 (16 clocks per bit), FIFO depth 4.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       core_reset_n, rx, rd, clr_err;
    logic [7:0] rdata;
    logic       rvalid, frame_err, overrun;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.TICK_DIV(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk_core     (clk),
        .core_reset_n (core_reset_n),
        .rx           (rx),
        .rd           (rd),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(16);
        end
        rx = stop;
        cyc(16);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rx = 1'b1; rd = 1'b0; clr_err = 1'b0; core_reset_n = 1'b0;
        #3;
        checks++; if ({rvalid, frame_err, overrun, rdata} !== 11'd0) begin errors++;
            $display("FAIL reset_outputs: got rvalid=%b ferr=%b ovr=%b rdata=%h want all 0", rvalid, frame_err, overrun, rdata); end
        cyc(3);
        core_reset_n = 1'b1;
        cyc(4);
        checks++; if ({rvalid, frame_err, overrun} !== 3'd0) begin errors++;
            $display("FAIL post_reset_idle: got rvalid=%b ferr=%b ovr=%b want 0", rvalid, frame_err, overrun); end
    endtask

    task automatic test_frame_55();
        int lat;
        lat = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (lat < 200 && !rvalid) begin cyc(1); lat++; end
            end
        join
        checks++; if (!(rvalid === 1'b1 && lat <= 163)) begin errors++;
            $display("FAIL frame55_latency: got rvalid=%b after %0d cycles want 1 within 163", rvalid, lat); end
        checks++; if (rdata !== 8'h55) begin errors++;
            $display("FAIL frame55_data: got %h want 55", rdata); end
        checks++; if (frame_err !== 1'b0) begin errors++;
            $display("FAIL frame55_ferr: got %b want 0", frame_err); end
        pop_one();
        checks++; if (rvalid !== 1'b0) begin errors++;
            $display("FAIL frame55_pop_empty: got rvalid=%b want 0", rvalid); end
        rd = 1'b1; cyc(3); rd = 1'b0;
        checks++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin errors++;
            $display("FAIL rd_when_empty: got rvalid=%b rdata=%h want 0/00", rvalid, rdata); end
    endtask

    task automatic test_false_start();
        rx = 1'b0; cyc(4); rx = 1'b1; cyc(40);
        checks++; if ({rvalid, frame_err, overrun} !== 3'd0) begin errors++;
            $display("FAIL false_start: got rvalid=%b ferr=%b ovr=%b want 0", rvalid, frame_err, overrun); end
        send_byte(8'hC3, 1'b1); cyc(2);
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hC3) begin errors++;
            $display("FAIL after_false_start: got rvalid=%b rdata=%h want 1/c3", rvalid, rdata); end
        pop_one();
        checks++; if (rvalid !== 1'b0) begin errors++;
            $display("FAIL after_false_start_pop: got rvalid=%b want 0", rvalid); end
    endtask

    task automatic test_frame_err();
        send_byte(8'hA5, 1'b0); cyc(4);
        checks++; if (frame_err !== 1'b1 || rvalid !== 1'b0) begin errors++;
            $display("FAIL bad_stop: got ferr=%b rvalid=%b want 1/0", frame_err, rvalid); end
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++;
            $display("FAIL clr_ferr: got %b want 0", frame_err); end
    endtask

    task automatic test_break();
        rx = 1'b0; cyc(200);
        checks++; if (frame_err !== 1'b1) begin errors++;
            $display("FAIL break_first_err: got %b want 1", frame_err); end
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        cyc(250);
        checks++; if (frame_err !== 1'b0 || rvalid !== 1'b0) begin errors++;
            $display("FAIL break_single_err: got ferr=%b rvalid=%b want 0/0", frame_err, rvalid); end
        rx = 1'b1; cyc(20);
        checks++; if (frame_err !== 1'b0) begin errors++;
            $display("FAIL break_release: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        cyc(2);
        checks++; if (overrun !== 1'b1) begin errors++;
            $display("FAIL overrun_set: got %b want 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (rvalid !== 1'b1 || rdata !== 8'(i)) begin errors++;
                $display("FAIL overrun_pop%0d: got rvalid=%b rdata=%h want 1/%h", i, rvalid, rdata, 8'(i)); end
            pop_one();
        end
        checks++; if (rvalid !== 1'b0) begin errors++;
            $display("FAIL overrun_drained: got rvalid=%b want 0", rvalid); end
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL clr_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [$];
        logic [7:0] e;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        // Frame pushes on the edge 155 clocks after its start bit is driven.
        fork
            send_byte(8'h06, 1'b1);
            begin cyc(154); rd = 1'b1; cyc(1); rd = 1'b0; end
        join
        cyc(2);
        checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL full_push_pop_overrun: got %b want 0", overrun); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (rvalid !== 1'b1 || rdata !== e) begin errors++;
                $display("FAIL full_push_pop_data: got rvalid=%b rdata=%h want 1/%h", rvalid, rdata, e); end
            pop_one();
        end
        checks++; if (rvalid !== 1'b0) begin errors++;
            $display("FAIL full_push_pop_drained: got rvalid=%b want 0", rvalid); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h99, 1'b1);
        send_byte(8'h11, 1'b0);
        rx = 1'b1; cyc(4);
        rx = 1'b0; cyc(16);
        rx = 1'b1; cyc(16);
        rx = 1'b0; cyc(8);
        core_reset_n = 1'b0;
        #2;
        checks++; if ({rvalid, frame_err, overrun, rdata} !== 11'd0) begin errors++;
            $display("FAIL mid_reset_outputs: got rvalid=%b ferr=%b ovr=%b rdata=%h want all 0", rvalid, frame_err, overrun, rdata); end
        rx = 1'b1; cyc(3); core_reset_n = 1'b1; cyc(20);
        checks++; if ({rvalid, frame_err, overrun} !== 3'd0) begin errors++;
            $display("FAIL mid_reset_abandon: got rvalid=%b ferr=%b ovr=%b want 0", rvalid, frame_err, overrun); end
        send_byte(8'h3C, 1'b1); cyc(2);
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h3C || frame_err !== 1'b0) begin errors++;
            $display("FAIL mid_reset_next: got rvalid=%b rdata=%h ferr=%b want 1/3c/0", rvalid, rdata, frame_err); end
        pop_one();
    endtask

    task automatic test_random();
        logic [7:0] model_q [$];
        logic [7:0] b, e;
        logic       good, exp_ovr, exp_ferr;
        int         n;
        for (int r = 0; r < 4; r++) begin
            model_q.delete();
            exp_ovr = 1'b0; exp_ferr = 1'b0;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                good = ($urandom_range(0, 3) != 0);
                send_byte(b, good);
                cyc(4);
                if (!good) exp_ferr = 1'b1;
                else if (model_q.size() < DEPTH) model_q.push_back(b);
                else exp_ovr = 1'b1;
            end
            checks++; if (frame_err !== exp_ferr || overrun !== exp_ovr) begin errors++;
                $display("FAIL rand%0d_flags: got ferr=%b ovr=%b want %b/%b", r, frame_err, overrun, exp_ferr, exp_ovr); end
            while (model_q.size() > 0) begin
                e = model_q.pop_front();
                checks++; if (rvalid !== 1'b1 || rdata !== e) begin errors++;
                    $display("FAIL rand%0d_data: got rvalid=%b rdata=%h want 1/%h", r, rvalid, rdata, e); end
                pop_one();
            end
            checks++; if (rvalid !== 1'b0) begin errors++;
                $display("FAIL rand%0d_drained: got rvalid=%b want 0", r, rvalid); end
            clr_err = 1'b1; cyc(1); clr_err = 1'b0;
            checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++;
                $display("FAIL rand%0d_clear: got ferr=%b ovr=%b want 0/0", r, frame_err, overrun); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_false_start();
        test_frame_err();
        test_break();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
